// File: rtl/qrd_frame_scheduler_if.sv
// Handshake and status bundle between upstream producer, frame scheduler and
// result consumer of the sorted-QR decomposition pipeline.
interface qrd_frame_scheduler_if #(
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned OUT_DEPTH = 4
);
  localparam int unsigned CRED_W = $clog2(OUT_DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [TAG_W-1:0]  in_tag;
  logic              flush;
  logic              pipe_launch;
  logic              pipe_done;
  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_tag;
  logic [CRED_W-1:0] credits;
  logic              busy;

  // Producer/consumer side
  modport master (
    output in_valid, in_tag, flush, out_ready,
    input  in_ready, pipe_launch, pipe_done, out_valid, out_tag, credits, busy
  );

  // Scheduler side
  modport slave (
    input  in_valid, in_tag, flush, out_ready,
    output in_ready, pipe_launch, pipe_done, out_valid, out_tag, credits, busy
  );
endinterface

// File: rtl/qrd_frame_scheduler.sv
// Credit-based launch scheduler for a fixed-latency, non-stalling QR pipeline:
// tracks frames in flight with a valid/tag delay line and buffers results in a tag FIFO.
module qrd_frame_scheduler #(
  parameter int unsigned PIPE_LAT  = 85,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned TAG_W     = 4
) (
  input logic                  clk,
  input logic                  rst,
  qrd_frame_scheduler_if.slave bus
);
  localparam int unsigned CRED_W = $clog2(OUT_DEPTH + 1);
  localparam int unsigned PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [CRED_W-1:0] FULL_CRED = CRED_W'(OUT_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(OUT_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FULL} state_e;

  state_e              state_q, state_d;
  logic [CRED_W-1:0]   credits_q, credits_d;
  logic [CRED_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PIPE_LAT-1:0] sr_vld_q, sr_vld_d;
  logic [TAG_W-1:0]    sr_tag_q [PIPE_LAT];
  logic [TAG_W-1:0]    fifo_q   [OUT_DEPTH];
  logic                launch_c, push_c, pop_c;

  // Reset only gates the visible strobes; state is already held by the async clear.
  assign launch_c        = bus.in_valid && (credits_q != '0) && !bus.flush;
  assign bus.in_ready    = rst && (credits_q != '0) && !bus.flush;
  assign bus.pipe_launch = rst && launch_c;
  assign push_c          = sr_vld_q[PIPE_LAT-1] && !bus.flush;
  assign bus.pipe_done   = push_c;
  assign bus.out_valid   = (count_q != '0);
  assign pop_c           = bus.out_valid && bus.out_ready && !bus.flush;
  assign bus.out_tag     = bus.out_valid ? fifo_q[rd_ptr_q] : '0;
  assign bus.credits     = credits_q;
  assign bus.busy        = (state_q != S_IDLE);

  // Next-state: credits, FIFO bookkeeping, delay line and FSM
  always_comb begin
    state_d   = state_q;
    credits_d = credits_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    sr_vld_d  = (sr_vld_q << 1) | PIPE_LAT'(launch_c);

    if (launch_c && !pop_c)      credits_d = credits_q - CRED_W'(1);
    else if (pop_c && !launch_c) credits_d = credits_q + CRED_W'(1);

    if (push_c && !pop_c)      count_d = count_q + CRED_W'(1);
    else if (pop_c && !push_c) count_d = count_q - CRED_W'(1);

    if (push_c) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);

    // All credits home means nothing in flight and nothing buffered.
    case (state_q)
      S_IDLE:   if (launch_c) state_d = (credits_d == '0) ? S_FULL : S_ACTIVE;
      S_ACTIVE: begin
        if (credits_d == '0)            state_d = S_FULL;
        else if (credits_d == FULL_CRED) state_d = S_IDLE;
      end
      S_FULL:   if (pop_c) state_d = (credits_d == FULL_CRED) ? S_IDLE : S_ACTIVE;
      default:  state_d = S_IDLE;
    endcase

    if (bus.flush) begin
      sr_vld_d  = '0;
      credits_d = FULL_CRED;
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      credits_q <= FULL_CRED;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      sr_vld_q  <= '0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      sr_vld_q  <= sr_vld_d;
    end
  end

  // Tag payloads need no reset: validity lives in sr_vld_q and count_q.
  always_ff @(posedge clk) begin
    sr_tag_q[0] <= bus.in_tag;
    for (int unsigned i = 1; i < PIPE_LAT; i++) sr_tag_q[i] <= sr_tag_q[i-1];
    if (push_c) fifo_q[wr_ptr_q] <= sr_tag_q[PIPE_LAT-1];
  end
endmodule

// File: tb/tb_qrd_frame_scheduler.sv
// Scoreboard bench for qrd_frame_scheduler: a queue-based reference of frames in
// flight and buffered results, directed scenarios followed by randomized traffic.
module tb_qrd_frame_scheduler;
  localparam int PIPE_LAT  = 85;
  localparam int OUT_DEPTH = 4;
  localparam int TAG_W     = 4;

  typedef struct {
    logic [TAG_W-1:0] tag;
    int               due;
  } flight_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  flight_t          done_q[$];
  logic [TAG_W-1:0] out_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qrd_frame_scheduler_if #(.TAG_W(TAG_W), .OUT_DEPTH(OUT_DEPTH)) bus ();

  qrd_frame_scheduler #(
    .PIPE_LAT (PIPE_LAT),
    .OUT_DEPTH(OUT_DEPTH),
    .TAG_W    (TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus.slave)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference side: admission decisions and launch bookkeeping, mid-cycle.
  always @(negedge clk) begin : model
    int   held;
    logic exp_ready;
    if (!rst_n) begin
      done_q.delete();
      out_q.delete();
    end
    held      = done_q.size() + out_q.size();
    exp_ready = rst_n && (held < OUT_DEPTH) && !bus.flush;
    check("in_ready", bus.in_ready, exp_ready);
    check("pipe_launch", bus.pipe_launch, bus.in_valid && exp_ready);
    check("credits", bus.credits, OUT_DEPTH - held);
    check("invariant", int'(bus.credits) + held, OUT_DEPTH);
    check("busy", bus.busy, held != 0);
    if (bus.in_valid && exp_ready)
      done_q.push_back('{tag: bus.in_tag, due: cyc + PIPE_LAT});
  end

  // Monitor: completions and result pops compared against the queues.
  always @(negedge clk) begin : scoreboard
    logic             exp_done;
    logic [TAG_W-1:0] head;
    flight_t          f;
    #1;
    if (!rst_n) begin
      done_q.delete();
      out_q.delete();
    end
    exp_done = rst_n && !bus.flush && (done_q.size() != 0) && (done_q[0].due == cyc);
    check("pipe_done", bus.pipe_done, exp_done);
    head = (out_q.size() != 0) ? out_q[0] : '0;
    check("out_valid", bus.out_valid, out_q.size() != 0);
    check("out_tag", bus.out_tag, head);
    if (bus.flush || !rst_n) begin
      done_q.delete();
      out_q.delete();
    end else begin
      if ((out_q.size() != 0) && bus.out_ready) void'(out_q.pop_front());
      if (exp_done) begin
        f = done_q.pop_front();
        out_q.push_back(f.tag);
      end
    end
  end

  task automatic drive(input logic v, input logic [TAG_W-1:0] t, input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_tag    = t;
    bus.out_ready = rdy;
    bus.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, '0, rdy, 1'b0);
  endtask

  initial begin : stim
    int lat, nl, t, t5c, c5_ready, c5_busy;
    bus.in_valid  = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    idle(3, 1'b0);
    rst_n = 1'b1;

    // Single frame, tag 5
    lat = 0;
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      if (bus.pipe_done) lat = k;
      else begin @(posedge clk); #1; end
    end
    check("single_latency", lat, PIPE_LAT);
    idle(4, 1'b0);
    check("single_out_tag", bus.out_tag, 5);
    idle(1, 1'b1);
    idle(2, 1'b0);
    check("single_idle", bus.busy, 0);

    // Back-pressure: tags 1..6, out_ready low except two single pops
    nl = 0; t = 1; t5c = -1; c5_ready = -1; c5_busy = -1;
    for (int c = 0; c < 300 && t <= 6; c++) begin
      bus.in_valid  = 1'b1;
      bus.in_tag    = TAG_W'(t);
      bus.out_ready = (c == 120) || (c == 150);
      bus.flush     = 1'b0;
      #1;
      if (c == 5) begin c5_ready = int'(bus.in_ready); c5_busy = int'(bus.busy); end
      if (bus.pipe_launch) begin
        if (c < 10) nl++;
        if (t == 5) t5c = c;
        t++;
      end
      @(posedge clk); #1;
    end
    check("bp_launches", nl, 4);
    check("bp_full_ready", c5_ready, 0);
    check("bp_full_busy", c5_busy, 1);
    check("bp_tag5_cycle", t5c, 121);
    idle(200, 1'b1);

    // Streaming with out_ready high: credit-limited bursts of four
    t = 0;
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = 1'b1;
      bus.in_tag    = TAG_W'(t);
      bus.out_ready = 1'b1;
      bus.flush     = 1'b0;
      #1;
      if (bus.pipe_launch) t++;
      @(posedge clk); #1;
    end
    check("stream_launches", t, 20);
    idle(200, 1'b1);

    // Flush with one buffered and three in flight
    drive(1'b1, 4'd10, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 200 && !bus.out_valid; k++) begin @(posedge clk); #1; end
    check("flush_setup", bus.out_valid, 1);
    drive(1'b1, 4'd11, 1'b0, 1'b0);
    drive(1'b1, 4'd12, 1'b0, 1'b0);
    drive(1'b1, 4'd13, 1'b0, 1'b0);
    idle(5, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1);
    check("flush_credits", bus.credits, OUT_DEPTH);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_busy", bus.busy, 0);
    idle(120, 1'b1);

    // Reset 40 cycles after two launches
    drive(1'b1, 4'd2, 1'b0, 1'b0);
    drive(1'b1, 4'd3, 1'b0, 1'b0);
    idle(38, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_tag   = 4'd9;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_pipe_launch", bus.pipe_launch, 0);
    check("rst_pipe_done", bus.pipe_done, 0);
    check("rst_credits", bus.credits, OUT_DEPTH);
    check("rst_busy", bus.busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_tag", bus.out_tag, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_first_launch", bus.pipe_launch, 1);
    @(posedge clk); #1;
    idle(150, 1'b1);

    // Randomized traffic with alternating consumer pressure and rare flushes
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 99) < 70, TAG_W'($urandom),
            $urandom_range(0, 99) < (((c / 500) % 2 == 0) ? 80 : 20),
            $urandom_range(0, 299) == 0);
    end
    idle(200, 1'b1);
    check("final_idle", bus.busy, 0);
    check("final_credits", bus.credits, OUT_DEPTH);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
